// File: rtl/scarv_ext_int_ctrl.sv
// scarv_ext_int_ctrl: synchronise, latch, mask and prioritise NUM_IRQ board lines into the CPU interrupt/cause ports.
// Edge->cpu_int_external in SYNC_STAGES+2 cycles, no backpressure; `define INT_CTRL_NMI_EN builds the NMI path.
module scarv_ext_int_ctrl #(
  parameter int                 NUM_IRQ     = 4,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '1,
  parameter int                 CAUSE_W     = 4
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               irq_ack_valid,
  input  logic [CAUSE_W-1:0] irq_ack_cause,
  input  logic               sw_set,
  input  logic               sw_clr,
  input  logic               nmi_in,
  input  logic               nmi_ack,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               cpu_int_external,
  output logic [CAUSE_W-1:0] cpu_int_ext_cause,
  output logic               cpu_int_software,
  output logic               cpu_int_nmi
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] h;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] masked;
  logic [CAUSE_W-1:0] cause_nxt;

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~h;
  assign masked = pending & irq_enable;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      h <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      h <= s;
    end
  end

  // Out-of-range ack causes match no line and are dropped here.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      ack_clr[i] = irq_ack_valid && (irq_ack_cause == CAUSE_W'(i));
  end

  // Edge lines: a new rise beats a same-cycle ack. Level lines follow the synchronised input.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) pending_nxt[i] = rise[i] | (pending[i] & ~ack_clr[i]);
      else              pending_nxt[i] = s[i];
    end
  end

  always_comb begin
    cause_nxt = cpu_int_ext_cause;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (masked[i]) cause_nxt = CAUSE_W'(i);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      pending           <= '0;
      irq_pending       <= '0;
      cpu_int_external  <= 1'b0;
      cpu_int_ext_cause <= '0;
      cpu_int_software  <= 1'b0;
    end else begin
      pending           <= pending_nxt;
      irq_pending       <= pending;
      cpu_int_external  <= |masked;
      cpu_int_ext_cause <= cause_nxt;
      if (sw_set)      cpu_int_software <= 1'b1;
      else if (sw_clr) cpu_int_software <= 1'b0;
    end
  end

`ifdef INT_CTRL_NMI_EN
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic                   nmi_h;
  logic                   nmi_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      nmi_sync <= '0;
      nmi_h    <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_in};
      nmi_h    <= nmi_sync[SYNC_STAGES-1];
      if (nmi_sync[SYNC_STAGES-1] && !nmi_h) nmi_q <= 1'b1;
      else if (nmi_ack)                      nmi_q <= 1'b0;
    end
  end

  assign cpu_int_nmi = nmi_q;
`else
  logic unused_nmi;
  assign unused_nmi  = nmi_in ^ nmi_ack;
  assign cpu_int_nmi = 1'b0;
`endif

endmodule

// File: tb/tb_scarv_ext_int_ctrl.sv
// Directed bench: edge-sensitive instance (default EDGE_MASK) plus a level-line instance (EDGE_MASK=4'h7).
module tb_scarv_ext_int_ctrl;

  logic       g_clk = 1'b0;
  logic       g_resetn;
  logic [3:0] irq_in, irq_in_l;
  logic [3:0] irq_enable, irq_enable_l;
  logic       irq_ack_valid;
  logic [3:0] irq_ack_cause;
  logic       sw_set, sw_clr, nmi_in, nmi_ack;

  logic [3:0] pend_e, pend_l, cause_e, cause_l;
  logic       ext_e, ext_l, sw_e, sw_l, nmi_e, nmi_l;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_nmi_on;

  always #5 g_clk = ~g_clk;

  scarv_ext_int_ctrl u_edge (
    .g_clk(g_clk), .g_resetn(g_resetn), .irq_in(irq_in), .irq_enable(irq_enable),
    .irq_ack_valid(irq_ack_valid), .irq_ack_cause(irq_ack_cause),
    .sw_set(sw_set), .sw_clr(sw_clr), .nmi_in(nmi_in), .nmi_ack(nmi_ack),
    .irq_pending(pend_e), .cpu_int_external(ext_e), .cpu_int_ext_cause(cause_e),
    .cpu_int_software(sw_e), .cpu_int_nmi(nmi_e)
  );

  scarv_ext_int_ctrl #(.EDGE_MASK(4'h7)) u_lvl (
    .g_clk(g_clk), .g_resetn(g_resetn), .irq_in(irq_in_l), .irq_enable(irq_enable_l),
    .irq_ack_valid(irq_ack_valid), .irq_ack_cause(irq_ack_cause),
    .sw_set(sw_set), .sw_clr(sw_clr), .nmi_in(nmi_in), .nmi_ack(nmi_ack),
    .irq_pending(pend_l), .cpu_int_external(ext_l), .cpu_int_ext_cause(cause_l),
    .cpu_int_software(sw_l), .cpu_int_nmi(nmi_l)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [3:0] k);
    irq_ack_valid = 1'b1;
    irq_ack_cause = k;
    tick();
    irq_ack_valid = 1'b0;
    irq_ack_cause = 4'h0;
  endtask

  initial begin
`ifdef INT_CTRL_NMI_EN
    exp_nmi_on = 1'b1;
`else
    exp_nmi_on = 1'b0;
`endif
    g_resetn = 1'b0; irq_in = 4'hF; irq_in_l = 4'h0;
    irq_enable = 4'hF; irq_enable_l = 4'h0;
    irq_ack_valid = 1'b0; irq_ack_cause = 4'h0;
    sw_set = 1'b0; sw_clr = 1'b0; nmi_in = 1'b0; nmi_ack = 1'b0;

    // 1 reset, then line 0 wins after 4 cycles
    tick(3);
    chk("rst_pend", pend_e, 4'h0);
    chk("rst_ext", ext_e, 1'b0);
    chk("rst_cause", cause_e, 4'h0);
    chk("rst_sw", sw_e, 1'b0);
    chk("rst_nmi", nmi_e, 1'b0);
    chk("rst_lvl_ext", ext_l, 1'b0);
    g_resetn = 1'b1;
    tick(3);
    chk("lat_ext_early", ext_e, 1'b0);
    tick();
    chk("lat_ext", ext_e, 1'b1);
    chk("lat_cause", cause_e, 4'h0);
    chk("lat_pend", pend_e, 4'hF);
    irq_in = 4'h0;
    ack(4'h0); ack(4'h1); ack(4'h2); ack(4'h3);
    tick(2);
    chk("clr_ext", ext_e, 1'b0);
    chk("clr_pend", pend_e, 4'h0);

    // 2 edge and priority
    irq_in = 4'b0100; tick(2);
    irq_in = 4'b0000; tick(2);
    irq_in = 4'b0010; tick(2);
    irq_in = 4'b0000; tick(6);
    chk("prio_pend", pend_e, 4'b0110);
    chk("prio_ext", ext_e, 1'b1);
    chk("prio_cause", cause_e, 4'h1);
    ack(4'h1);
    tick();
    chk("ack1_cause", cause_e, 4'h2);
    chk("ack1_ext", ext_e, 1'b1);
    ack(4'h2);
    tick();
    chk("ack2_ext", ext_e, 1'b0);
    chk("ack2_cause_hold", cause_e, 4'h2);

    // 3 collision of new edge with ack; out-of-range ack
    irq_in = 4'b1000; tick(2);
    irq_in = 4'b0000; tick(6);
    chk("l3_pend", pend_e, 4'b1000);
    irq_in = 4'b1000;
    tick(2);
    ack(4'h3);
    tick();
    chk("collide_pend", pend_e, 4'b1000);
    chk("collide_cause", cause_e, 4'h3);
    irq_in = 4'b0000; tick(4);
    ack(4'h9);
    tick(2);
    chk("ack9_pend", pend_e, 4'b1000);
    chk("ack9_ext", ext_e, 1'b1);
    ack(4'h3);
    tick(2);
    chk("ack3_pend", pend_e, 4'h0);
    chk("ack3_ext", ext_e, 1'b0);

    // 4 level line and mask
    irq_in_l = 4'b1000; irq_enable_l = 4'h8;
    tick(4);
    chk("lvl_ext", ext_l, 1'b1);
    chk("lvl_cause", cause_l, 4'h3);
    irq_enable_l = 4'h0;
    tick();
    chk("mask_ext", ext_l, 1'b0);
    chk("mask_pend", pend_l, 4'b1000);
    ack(4'h3);
    tick();
    chk("lvl_ack_ign", pend_l, 4'b1000);
    irq_enable_l = 4'h8;
    tick();
    chk("reen_ext", ext_l, 1'b1);
    irq_in_l = 4'b0000;
    tick(5);
    chk("lvl_drop_pend", pend_l, 4'h0);
    chk("lvl_drop_ext", ext_l, 1'b0);

    // 5 software latch and NMI
    sw_set = 1'b1; sw_clr = 1'b1;
    tick();
    chk("sw_both", sw_e, 1'b1);
    sw_set = 1'b0;
    tick();
    chk("sw_clr", sw_e, 1'b0);
    sw_clr = 1'b0; sw_set = 1'b1;
    tick();
    sw_set = 1'b0;
    chk("sw_set", sw_e, 1'b1);
    nmi_in = 1'b1;
    tick(2);
    chk("nmi_early", nmi_e, 1'b0);
    tick();
    chk("nmi_set", nmi_e, exp_nmi_on);
    tick(2);
    chk("nmi_hold", nmi_e, exp_nmi_on);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    chk("nmi_ack", nmi_e, 1'b0);

    // 6 asynchronous reset mid-request
    irq_in = 4'b0001;
    tick(5);
    chk("pre_rst_ext", ext_e, 1'b1);
    #3;
    g_resetn = 1'b0;
    #1;
    chk("arst_ext", ext_e, 1'b0);
    chk("arst_pend", pend_e, 4'h0);
    chk("arst_sw", sw_e, 1'b0);
    chk("arst_nmi", nmi_e, 1'b0);
    irq_in = 4'b0000;
    nmi_in = 1'b0;
    tick(2);
    g_resetn = 1'b1;
    tick(6);
    chk("post_rst_ext", ext_e, 1'b0);
    chk("post_rst_pend", pend_e, 4'h0);
    chk("post_rst_cause", cause_e, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
